alu_result_bcd: RTL
===================

Name: alu_result_bcd

Overview:
Sequential binary-to-BCD converter sitting directly downstream of the ALU result bus. It takes the ALU's 2N-bit result Y and converts it to decimal digits by iterative double-dabble, one bit per cycle. An optional two's-complement sign interpretation is supported. Its digit outputs feed the hex7seg decoders, so HEX displays show the result in decimal instead of hex.

Parameters:
W, 8, input binary width; equals the ALU result width 2N.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS >= 2^W. Elaboration fails otherwise.

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
rst_n  input  1  asynchronous reset, active-low
start  input  1  conversion request; sampled on rising clk edge only while idle
bin  input  W  binary value to convert; sampled with start
signed_mode  input  1  1 = treat bin as two's complement; sampled with start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd/neg are updated
bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0]
neg  output  1  result was negative (signed_mode=1 and bin[W-1]=1)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd=0, neg=0, internal shift/count registers cleared. Reset mid-conversion aborts the conversion; no done pulse occurs afterwards.
- FSM has two states: IDLE and CONV.
- IDLE with start=1 at edge E0:
  - Capture the magnitude: -bin (W-bit two's complement) if signed_mode and bin[W-1] are both 1, else bin.
  - Capture the neg flag into a pending register; clear the working BCD accumulator; count=0; go to CONV.
  - busy=1 from E0 onward.
- CONV, each edge:
  - Every accumulator digit >=5 gets +3.
  - The whole {accumulator, magnitude} register then shifts left 1; the magnitude MSB enters the accumulator LSB.
  - count increments.
- On the W-th CONV edge (count==W-1 at that edge):
  - bcd <= final accumulator; neg <= pending flag; done <= 1; busy <= 0; state <= IDLE.
  - Latency: start at E0 gives done/bcd valid after edge E0+W. For W=8, done is high during the cycle after the 8th shift edge.
- done is high for exactly one cycle; it clears on the next edge.
- bcd and neg hold their last value between conversions. They change only together with done.
- start while busy=1 is ignored (not queued). start high during the done cycle is accepted, since the FSM is already IDLE, so back-to-back throughput is one result per W+1 cycles.
- Changes on bin/signed_mode after the capture edge do not affect the conversion in flight.
- Magnitude edge case: signed_mode=1 with bin=8'h80 gives magnitude 128. This fits because the magnitude is held unsigned in W bits.
- No X on outputs at any time after reset.

Optional Feature:
BCD_LEADING_BLANK_EN
- Defined:
  - Adds output blank, width DIGITS, registered and updated with done.
  - blank[i]=1 when digit i and all more-significant digits are 0, for i>=1.
  - blank[0] is always 0, so zero displays as "0".
  - Reset value: all zeros.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Unsigned max: start, bin=8'hFF, signed_mode=0 -> done exactly 9 edges after capture... i.e. after edge E0+8; bcd=12'h255, neg=0.
- Signed minimum: bin=8'h80, signed_mode=1 -> bcd=12'h128, neg=1. Also bin=8'hFF, signed_mode=1 -> bcd=12'h001, neg=1.
- Zero and two-digit value: bin=8'h00 -> bcd=12'h000. bin=8'h63 -> bcd=12'h099. With BCD_LEADING_BLANK_EN: blank=3'b100 for 99, and 3'b110 for 0 and for 7.
- start ignored while busy: start with bin=8'h2A, pulse start with bin=8'h11 three cycles later -> a single done, bcd=12'h042. Then start held during the done cycle with bin=8'h11 -> busy next cycle, and the second done 9 cycles after the first with bcd=12'h017.
- Reset mid-conversion: start with bin=8'hC8, drop rst_n after 4 cycles -> busy=0, done=0, bcd=0, neg=0 immediately (asynchronously). After release, no done until a new start.
- Value hold: after a conversion yielding 12'h255, toggle bin for 20 cycles without start -> bcd stays 12'h255 and done stays 0.

Source files
------------

// File: rtl/alu_result_bcd.sv
// Sequential double-dabble binary-to-BCD converter for the ALU result bus, one bit per cycle.
// Optional BCD_LEADING_BLANK_EN adds a registered leading-zero blanking mask for the digit displays.
module alu_result_bcd #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
`ifdef BCD_LEADING_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  // True when DIGITS decimal digits can represent every W-bit magnitude.
  function automatic bit digits_fit(input int unsigned w, input int unsigned d);
    longint unsigned lim;
    longint unsigned p;
    lim = (w >= 63) ? 64'h7FFF_FFFF_FFFF_FFFF : (64'd1 << w);
    p   = 64'd1;
    for (int unsigned i = 0; i < d; i++) begin
      if (p < lim) p = p * 64'd10;
    end
    return p >= lim;
  endfunction

  localparam bit FIT = digits_fit(W, DIGITS);

  generate
    if (!FIT) begin : g_digits_check
      $error("alu_result_bcd: DIGITS too small for W");
    end
  endgenerate

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [W-1:0]    mag;
  logic [BW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            neg_pend;
  logic [BW-1:0]   adj_c;
  logic [BW-1:0]   acc_next_c;

  // Add-3 correction on every digit that would overflow past 9 when doubled.
  always_comb begin
    adj_c = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next_c = {adj_c[BW-2:0], mag[W-1]};
  end

`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] blank_c;

  // Digit i blanks only if it and every digit above it are zero; units never blank.
  always_comb begin
    logic zero_run;
    blank_c  = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run   = zero_run & (acc_next_c[4*i +: 4] == 4'd0);
      blank_c[i] = zero_run;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mag      <= '0;
      acc      <= '0;
      count    <= '0;
      neg_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
      blank    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Magnitude stays unsigned in W bits, so the most negative value still fits.
            mag      <= (signed_mode && bin[W-1]) ? W'(~bin + W'(1)) : bin;
            neg_pend <= signed_mode & bin[W-1];
            acc      <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_next_c;
          mag   <= mag << 1;
          count <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            bcd   <= acc_next_c;
            neg   <= neg_pend;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef BCD_LEADING_BLANK_EN
            blank <= blank_c;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
